// File: rtl/imem_boot_loader.sv
// Byte-stream boot loader: parses a length/data/checksum frame, writes assembled words
// into instruction memory and releases the core only after the checksum verifies.
`timescale 1ns/1ps
module imem_boot_loader #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned BASE   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    localparam int unsigned IDX_W = ADDR_W + 1;
    localparam int unsigned DEPTH = 1 << ADDR_W;

    localparam logic [2:0] S_LEN_LO = 3'd0;
    localparam logic [2:0] S_LEN_HI = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_CSUM   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;
    localparam logic [2:0] S_ERR    = 3'd5;

    logic [2:0]        r_state,    w_state_nx;
    logic [7:0]        r_len_lo,   w_len_lo_nx;
    logic [15:0]       r_n,        w_n_nx;
    logic [1:0]        r_lane,     w_lane_nx;
    logic [IDX_W-1:0]  r_idx,      w_idx_nx;
    logic [23:0]       r_buf,      w_buf_nx;
    logic [7:0]        r_csum,     w_csum_nx;
    logic              r_ready,    w_ready_nx;
    logic              r_we,       w_we_nx;
    logic [ADDR_W-1:0] r_addr,     w_addr_nx;
    logic [31:0]       r_wdata,    w_wdata_nx;
    logic              r_hold,     w_hold_nx;
    logic              r_done,     w_done_nx;
    logic              r_error,    w_error_nx;

    logic              w_accept;
    logic [15:0]       w_n_in;
    logic              w_last;

    assign w_accept = in_valid & r_ready;
    assign w_n_in   = {in_data, r_len_lo};
    assign w_last   = (16'(r_idx) + 16'd1) == r_n;

    // Next-state and next-output logic; everything advances only on an accepted byte.
    always_comb begin
        w_state_nx  = r_state;
        w_len_lo_nx = r_len_lo;
        w_n_nx      = r_n;
        w_lane_nx   = r_lane;
        w_idx_nx    = r_idx;
        w_buf_nx    = r_buf;
        w_csum_nx   = r_csum;
        w_we_nx     = 1'b0;
        w_addr_nx   = r_addr;
        w_wdata_nx  = r_wdata;

        if (w_accept) begin
            case (r_state)
                S_LEN_LO: begin
                    w_len_lo_nx = in_data;
                    w_state_nx  = S_LEN_HI;
                end
                S_LEN_HI: begin
                    w_n_nx = w_n_in;
                    if (w_n_in == 16'd0) begin
                        w_state_nx = S_CSUM;
                    end else if (32'(w_n_in) > DEPTH) begin
                        w_state_nx = S_ERR;
                    end else begin
                        w_state_nx = S_DATA;
                    end
                end
                S_DATA: begin
                    w_csum_nx = r_csum ^ in_data;
                    w_lane_nx = r_lane + 2'd1;
                    case (r_lane)
                        2'd0: w_buf_nx[7:0]   = in_data;
                        2'd1: w_buf_nx[15:8]  = in_data;
                        2'd2: w_buf_nx[23:16] = in_data;
                        default: begin
                            w_we_nx    = 1'b1;
                            w_wdata_nx = {in_data, r_buf};
                            w_addr_nx  = ADDR_W'(BASE) + r_idx[ADDR_W-1:0];
                            w_idx_nx   = r_idx + IDX_W'(1);
                            if (w_last) begin
                                w_state_nx = S_CSUM;
                            end
                        end
                    endcase
                end
                S_CSUM: begin
                    w_state_nx = (in_data == r_csum) ? S_DONE : S_ERR;
                end
                default: ;
            endcase
        end

        w_ready_nx = (w_state_nx != S_DONE) && (w_state_nx != S_ERR);
        w_done_nx  = (w_state_nx == S_DONE);
        w_error_nx = (w_state_nx == S_ERR);
        w_hold_nx  = (w_state_nx != S_DONE);
    end

    // State and registered outputs; in_ready stays low for the reset-release cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_LEN_LO;
            r_len_lo <= '0;
            r_n      <= '0;
            r_lane   <= '0;
            r_idx    <= '0;
            r_buf    <= '0;
            r_csum   <= '0;
            r_ready  <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= ADDR_W'(BASE);
            r_wdata  <= '0;
            r_hold   <= 1'b1;
            r_done   <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_len_lo <= w_len_lo_nx;
            r_n      <= w_n_nx;
            r_lane   <= w_lane_nx;
            r_idx    <= w_idx_nx;
            r_buf    <= w_buf_nx;
            r_csum   <= w_csum_nx;
            r_ready  <= w_ready_nx;
            r_we     <= w_we_nx;
            r_addr   <= w_addr_nx;
            r_wdata  <= w_wdata_nx;
            r_hold   <= w_hold_nx;
            r_done   <= w_done_nx;
            r_error  <= w_error_nx;
        end
    end

    assign in_ready   = r_ready;
    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign cpu_hold   = r_hold;
    assign done       = r_done;
    assign error      = r_error;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: framed images, checksum/length faults,
// valid gaps and mid-frame reset, with a negedge write monitor.
`timescale 1ns/1ps
module tb_imem_boot_loader;

    localparam int unsigned ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              error;

    int          n_checks = 0;
    int          n_errors = 0;
    int          wr_cnt   = 0;
    logic [31:0] wr_addr [8];
    logic [31:0] wr_data [8];

    imem_boot_loader #(.ADDR_W(ADDR_W), .BASE(0)) u_dut (
        .clk        (clk),
        .rst        (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we) begin
            if (wr_cnt < 8) begin
                wr_addr[wr_cnt] = 32'(imem_addr);
                wr_data[wr_cnt] = imem_wdata;
            end
            wr_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        #1;
        chk({tag, " rst in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, " rst we"},       32'(imem_we),  32'd0);
        chk({tag, " rst addr"},     32'(imem_addr), 32'd0);
        chk({tag, " rst wdata"},    imem_wdata,    32'd0);
        chk({tag, " rst hold"},     32'(cpu_hold), 32'd1);
        chk({tag, " rst done"},     32'(done),     32'd0);
        chk({tag, " rst error"},    32'(error),    32'd0);
        wr_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            wr_addr[i] = '1;
            wr_data[i] = '1;
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk({tag, " release ready"}, 32'(in_ready), 32'd0);
        @(negedge clk);
        #1;
        chk({tag, " ready up"}, 32'(in_ready), 32'd1);
    endtask

    // One byte per call: waits for in_ready, holds valid for one edge, then idles a cycle.
    task automatic send_byte(input logic [7:0] b, input logic exp_we, input string tag);
        int n = 0;
        @(negedge clk);
        #1;
        while (!in_ready && n < 16) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            chk({tag, " ready timeout"}, 32'(in_ready), 32'd1);
            return;
        end
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        chk({tag, " we"}, 32'(imem_we), 32'(exp_we));
    endtask

    task automatic send_hdr(input logic [15:0] n, input string tag);
        send_byte(n[7:0],  1'b0, {tag, " len_lo"});
        send_byte(n[15:8], 1'b0, {tag, " len_hi"});
    endtask

    task automatic send_word(input logic [31:0] w, input string tag);
        send_byte(w[7:0],   1'b0, {tag, " b0"});
        send_byte(w[15:8],  1'b0, {tag, " b1"});
        send_byte(w[23:16], 1'b0, {tag, " b2"});
        send_byte(w[31:24], 1'b1, {tag, " b3"});
    endtask

    task automatic chk_end(input string tag, input logic exp_done);
        chk({tag, " done"},  32'(done),     32'(exp_done));
        chk({tag, " error"}, 32'(error),    32'(!exp_done));
        chk({tag, " hold"},  32'(cpu_hold), 32'(!exp_done));
        chk({tag, " ready"}, 32'(in_ready), 32'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;

        // Two-word image; XOR of 93 00 50 00 13 01 10 00 is 0xC1
        do_reset("t1");
        send_hdr(16'd2, "t1");
        send_word(32'h0050_0093, "t1 w0");
        send_word(32'h0010_0113, "t1 w1");
        chk("t1 hold before csum", 32'(cpu_hold), 32'd1);
        chk("t1 done before csum", 32'(done), 32'd0);
        send_byte(8'hC1, 1'b0, "t1 csum");
        chk_end("t1", 1'b1);
        @(negedge clk);
        #1;
        chk("t1 nwr",   32'(wr_cnt), 32'd2);
        chk("t1 addr0", wr_addr[0], 32'd0);
        chk("t1 data0", wr_data[0], 32'h0050_0093);
        chk("t1 addr1", wr_addr[1], 32'd1);
        chk("t1 data1", wr_data[1], 32'h0010_0113);
        chk("t1 sticky done", 32'(done), 32'd1);

        // Corrupted checksum
        do_reset("t2");
        send_hdr(16'd2, "t2");
        send_word(32'h0050_0093, "t2 w0");
        send_word(32'h0010_0113, "t2 w1");
        send_byte(8'hC0, 1'b0, "t2 csum");
        chk_end("t2", 1'b0);
        chk("t2 nwr", 32'(wr_cnt), 32'd2);

        // Length one past capacity
        do_reset("t3");
        send_hdr(16'd33, "t3");
        chk_end("t3", 1'b0);
        repeat (3) @(negedge clk);
        #1;
        chk("t3 nwr", 32'(wr_cnt), 32'd0);

        // Length exactly at capacity is accepted
        do_reset("t3b");
        send_hdr(16'd32, "t3b");
        chk("t3b error", 32'(error), 32'd0);
        chk("t3b ready", 32'(in_ready), 32'd1);

        // Empty image, good and bad checksum
        do_reset("t4a");
        send_hdr(16'd0, "t4a");
        send_byte(8'h00, 1'b0, "t4a csum");
        chk_end("t4a", 1'b1);
        chk("t4a nwr", 32'(wr_cnt), 32'd0);
        do_reset("t4b");
        send_hdr(16'd0, "t4b");
        send_byte(8'h10, 1'b0, "t4b csum");
        chk_end("t4b", 1'b0);

        // Toggling valid with random data in the gaps; EF^BE^AD^DE = 0x22
        do_reset("t5");
        send_hdr(16'd1, "t5");
        send_word(32'hDEAD_BEEF, "t5 w0");
        send_byte(8'h22, 1'b0, "t5 csum");
        chk_end("t5", 1'b1);
        @(negedge clk);
        #1;
        chk("t5 nwr",   32'(wr_cnt), 32'd1);
        chk("t5 addr0", wr_addr[0], 32'd0);
        chk("t5 data0", wr_data[0], 32'hDEAD_BEEF);

        // Reset mid-word, then a fresh image; 0D^F0^FE^CA = 0xC9
        do_reset("t6");
        send_hdr(16'd1, "t6a");
        send_byte(8'h11, 1'b0, "t6a b0");
        send_byte(8'h22, 1'b0, "t6a b1");
        rst_n = 1'b0;
        #1;
        chk("t6 async ready", 32'(in_ready), 32'd0);
        chk("t6 async hold",  32'(cpu_hold), 32'd1);
        do_reset("t6r");
        send_hdr(16'd1, "t6b");
        send_word(32'hCAFE_F00D, "t6b w0");
        send_byte(8'hC9, 1'b0, "t6b csum");
        chk_end("t6", 1'b1);
        @(negedge clk);
        #1;
        chk("t6 nwr",   32'(wr_cnt), 32'd1);
        chk("t6 addr0", wr_addr[0], 32'd0);
        chk("t6 data0", wr_data[0], 32'hCAFE_F00D);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
